// File: rtl/common_pkg.sv
// Shared pipeline types: forward selects and
// the shadow destination-tag bundle.
package common;

  typedef enum logic [1:0] {
    NO_FWD     = 2'd0,
    EX_MEM_FWD = 2'd1,
    MEM_WB_FWD = 2'd2
  } fwd_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } hz_tag_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam hz_tag_t HZ_BUBBLE = '{
    valid:     1'b0,
    rd:        REG_ZERO,
    reg_write: 1'b0,
    mem_read:  1'b0
  };

  function automatic logic hz_src(
    input hz_tag_t    t,
    input logic [4:0] rs
  );
    return t.valid && t.reg_write &&
           (t.rd != REG_ZERO) && (t.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-operand forward select from the EX/MEM
// shadow tags; the newest producer wins.
import common::*;

module fwd_select (
  input  logic [4:0] rs,
  input  hz_tag_t    ex_q,
  input  hz_tag_t    mem_q,
  output fwd_t       sel
);

  // EX producer beats older MEM producer
  always_comb begin
    sel = NO_FWD;
    if (hz_src(ex_q, rs))
      sel = EX_MEM_FWD;
    else if (hz_src(mem_q, rs))
      sel = MEM_WB_FWD;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use stall, branch flush and registered
// operand-forward selects for the EX stage.
import common::*;

module hazard_forward_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             branch_taken,
  output fwd_t             forward_a,
  output fwd_t             forward_b,
  output logic             stall,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  hz_tag_t ex_q;
  hz_tag_t mem_q;
  hz_tag_t ex_d;
  fwd_t    sel_a;
  fwd_t    sel_b;
  fwd_t    fa_d;
  fwd_t    fb_d;
  logic    load_use;
  logic    bubble;

  fwd_select u_fwd_a (
    .rs    (id_rs1),
    .ex_q  (ex_q),
    .mem_q (mem_q),
    .sel   (sel_a)
  );

  fwd_select u_fwd_b (
    .rs    (id_rs2),
    .ex_q  (ex_q),
    .mem_q (mem_q),
    .sel   (sel_b)
  );

  // hazard detect; a taken branch wins over stall
  always_comb begin
    load_use = id_valid && ex_q.valid &&
               ex_q.mem_read &&
               (ex_q.rd != REG_ZERO) &&
               ((ex_q.rd == id_rs1) ||
                (ex_q.rd == id_rs2));
    flush_if_id = branch_taken;
    flush_id_ex = branch_taken;
    stall       = load_use && !branch_taken;
    bubble      = stall || branch_taken ||
                  !id_valid;
    ex_d.valid     = 1'b1;
    ex_d.rd        = id_rd;
    ex_d.reg_write = id_reg_write;
    ex_d.mem_read  = id_mem_read;
    fa_d = sel_a;
    fb_d = sel_b;
    if (bubble) begin
      ex_d = HZ_BUBBLE;
      fa_d = NO_FWD;
      fb_d = NO_FWD;
    end
  end

  // shadow tag pipe and EX-aligned selects
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q      <= HZ_BUBBLE;
      mem_q     <= HZ_BUBBLE;
      forward_a <= NO_FWD;
      forward_b <= NO_FWD;
    end else begin
      mem_q     <= ex_q;
      ex_q      <= ex_d;
      forward_a <= fa_d;
      forward_b <= fb_d;
    end
  end

  // saturating stall / flush event counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (branch_taken && (flush_events != '1))
        flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector scoreboard bench for
// hazard_forward_unit.
import common::*;

module tb_hazard_forward_unit;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             branch_taken;
  fwd_t             forward_a;
  fwd_t             forward_b;
  logic             stall;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  hazard_forward_unit #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .branch_taken (branch_taken),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .stall        (stall),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  stl;
    logic  fl;
    fwd_t  fa;
    fwd_t  fb;
    int    sc;
    int    fe;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(
    input string name,
    input int    act,
    input int    req
  );
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, req);
    end
  endtask

  // drive one ID slot and queue its expectation
  task automatic issue(
    input string nm,
    input logic v, input int rs1, input int rs2,
    input int rd, input logic rw, input logic mr,
    input logic br,
    input logic e_stl, input logic e_fl,
    input fwd_t e_fa, input fwd_t e_fb,
    input int e_sc, input int e_fe
  );
    exp_t e;
    @(negedge clk);
    id_valid     = v;
    id_rs1       = 5'(rs1);
    id_rs2       = 5'(rs2);
    id_rd        = 5'(rd);
    id_reg_write = rw;
    id_mem_read  = mr;
    branch_taken = br;
    e.name = nm;
    e.stl  = e_stl;
    e.fl   = e_fl;
    e.fa   = e_fa;
    e.fb   = e_fb;
    e.sc   = e_sc;
    e.fe   = e_fe;
    sb_q.push_back(e);
  endtask

  // monitor: comb outputs before the edge,
  // registered outputs just after it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk({e.name, ".stall"}, int'(stall),
            int'(e.stl));
        chk({e.name, ".flush_if_id"},
            int'(flush_if_id), int'(e.fl));
        chk({e.name, ".flush_id_ex"},
            int'(flush_id_ex), int'(e.fl));
        @(posedge clk);
        #1;
        chk({e.name, ".forward_a"},
            int'(forward_a), int'(e.fa));
        chk({e.name, ".forward_b"},
            int'(forward_b), int'(e.fb));
        chk({e.name, ".stall_cycles"},
            int'(stall_cycles), e.sc);
        chk({e.name, ".flush_events"},
            int'(flush_events), e.fe);
      end
    end
  end

  task automatic chk_reset(input string nm);
    chk({nm, ".forward_a"}, int'(forward_a),
        int'(NO_FWD));
    chk({nm, ".forward_b"}, int'(forward_b),
        int'(NO_FWD));
    chk({nm, ".stall"}, int'(stall), 0);
    chk({nm, ".flush_if_id"},
        int'(flush_if_id), 0);
    chk({nm, ".flush_id_ex"},
        int'(flush_id_ex), 0);
    chk({nm, ".stall_cycles"},
        int'(stall_cycles), 0);
    chk({nm, ".flush_events"},
        int'(flush_events), 0);
  endtask

  initial begin
    int waited;
    reset_n      = 1'b0;
    id_valid     = 1'b0;
    id_rs1       = '0;
    id_rs2       = '0;
    id_rd        = '0;
    id_reg_write = 1'b0;
    id_mem_read  = 1'b0;
    branch_taken = 1'b0;
    #2;
    chk_reset("rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // back-to-back ALU
    issue("add5", 1, 1, 2, 5, 1, 0, 0,
          0, 0, NO_FWD, NO_FWD, 0, 0);
    issue("sub6", 1, 5, 7, 6, 1, 0, 0,
          0, 0, EX_MEM_FWD, NO_FWD, 0, 0);
    // distance-2
    issue("add5b", 1, 1, 2, 5, 1, 0, 0,
          0, 0, NO_FWD, NO_FWD, 0, 0);
    issue("nop", 0, 0, 0, 0, 0, 0, 0,
          0, 0, NO_FWD, NO_FWD, 0, 0);
    issue("or8", 1, 5, 5, 8, 1, 0, 0,
          0, 0, MEM_WB_FWD, MEM_WB_FWD, 0, 0);
    // double producer
    issue("add5c", 1, 1, 2, 5, 1, 0, 0,
          0, 0, NO_FWD, NO_FWD, 0, 0);
    issue("add5d", 1, 1, 2, 5, 1, 0, 0,
          0, 0, NO_FWD, NO_FWD, 0, 0);
    issue("sub9", 1, 5, 0, 9, 1, 0, 0,
          0, 0, EX_MEM_FWD, NO_FWD, 0, 0);
    // load-use
    issue("lw3", 1, 1, 0, 3, 1, 1, 0,
          0, 0, NO_FWD, NO_FWD, 0, 0);
    issue("add4stl", 1, 3, 1, 4, 1, 0, 0,
          1, 0, NO_FWD, NO_FWD, 1, 0);
    issue("add4go", 1, 3, 1, 4, 1, 0, 0,
          0, 0, MEM_WB_FWD, NO_FWD, 1, 0);
    // x0 writer, including a load
    issue("lw0", 1, 1, 0, 0, 1, 1, 0,
          0, 0, NO_FWD, NO_FWD, 1, 0);
    issue("add1x0", 1, 0, 0, 1, 1, 0, 0,
          0, 0, NO_FWD, NO_FWD, 1, 0);
    issue("add2x0", 1, 0, 0, 2, 1, 0, 0,
          0, 0, NO_FWD, NO_FWD, 1, 0);
    // branch coincident with load-use
    issue("lw3b", 1, 1, 0, 3, 1, 1, 0,
          0, 0, MEM_WB_FWD, NO_FWD, 1, 0);
    issue("brhz", 1, 3, 1, 4, 1, 0, 1,
          0, 1, NO_FWD, NO_FWD, 1, 1);
    issue("postbr", 1, 3, 1, 4, 1, 0, 0,
          0, 0, MEM_WB_FWD, NO_FWD, 1, 1);

    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d left expected 0",
               sb_q.size());
    end
    @(posedge clk);
    #3;
    // async reset mid-stream with a live hazard
    id_valid     = 1'b1;
    id_rs1       = 5'd4;
    branch_taken = 1'b1;
    #1;
    branch_taken = 1'b0;
    reset_n      = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    reset_n  = 1'b1;
    id_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("postrst");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard controller that produces the operand-forwarding selects consumed by the execute stage, plus stall and flush controls for the front end. It keeps a shadow pipeline of destination-register tags for the instructions in EX and MEM and compares them against the source registers of the instruction in ID. Forward selects are registered so they arrive aligned with that instruction's first cycle in EX. Sits beside the ID/EX pipeline register and drives forward_a/forward_b, the IF/ID and ID/EX stall/flush enables, and two performance counters.

## Interface
- CNT_W, 16: width of the saturating performance counters.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  5  ID source register 1.
- id_rs2  in  5  ID source register 2.
- id_rd  in  5  ID destination register.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- branch_taken  in  1  instruction currently in EX redirects the PC.
- forward_a  out  fwd_t  left-operand select for the instruction in EX.
- forward_b  out  fwd_t  right-operand and store-data select for the instruction in EX.
- stall  out  1  hold PC and IF/ID, insert a bubble into ID/EX.
- flush_if_id  out  1  squash IF/ID.
- flush_id_ex  out  1  squash ID/EX.
- stall_cycles  out  CNT_W  count of stall cycles, saturating.
- flush_events  out  CNT_W  count of taken-branch flushes, saturating.

## Operation
- Shadow stages ex_q and mem_q each hold {valid, rd, reg_write, mem_read}. Every cycle: mem_q <= ex_q, and ex_q <= the ID fields, or a bubble (valid=0) when stall or flush_id_ex is asserted.
- A stage is a forwarding source for rs when: valid && reg_write && rd != 0 && rd == rs.
- Next forward select, computed per operand from the ID inputs:
  - ex_q is a source: EX_MEM_FWD. The producer will be in MEM when the consumer is in EX.
  - otherwise mem_q is a source: MEM_WB_FWD.
  - otherwise NO_FWD.
  - EX_MEM_FWD has priority over MEM_WB_FWD.
- No WB-stage forwarding is needed. The register file performs write-before-read.
- Load-use stall: stall = id_valid && ex_q.valid && ex_q.mem_read && ex_q.rd != 0 && (ex_q.rd == id_rs1 || ex_q.rd == id_rs2).
  - Both rs fields are compared regardless of format. A false stall is acceptable.
  - While stalled, the next forward selects are NO_FWD because a bubble enters EX.
  - On the following cycle the load sits in mem_q, so the held instruction receives MEM_WB_FWD.
- Branch flush: branch_taken asserts flush_if_id and flush_id_ex in the same cycle.
  - Flush overrides stall: stall is forced to 0 and the next forward selects are NO_FWD.
- Counters:
  - stall_cycles increments on each cycle with stall=1.
  - flush_events increments on each cycle with branch_taken=1.
  - Both saturate at all-ones.
- id_valid=0 produces no stall and loads a bubble into ex_q.

## Timing
- Reset values: ex_q and mem_q valid=0; forward_a and forward_b are NO_FWD; stall=0; flushes=0; both counters 0.
- Reset mid-operation discards all shadow state immediately. There is no pending flush or stall after release.
- forward_a and forward_b are registered. Latency is 1 cycle from ID inputs to EX-aligned output.
- stall, flush_if_id and flush_id_ex are combinational from the current inputs and shadow state. Zero latency; they are valid before the same clock edge.
- A load-use hazard costs exactly one stall cycle. A taken branch costs exactly two squashed instructions.
- Simultaneous branch_taken and hazard: flush only. stall_cycles does not increment.

## Structure
- Shared package common already holds fwd_t (NO_FWD, EX_MEM_FWD, MEM_WB_FWD). Add the following there:
  - hz_tag_t struct {valid, rd, reg_write, mem_read};
  - REG_ZERO = 5'd0.
- One natural sub-module: fwd_select. It is combinational, takes (rs, ex_q, mem_q) and returns fwd_t. It is instantiated twice, once per operand.

## Test plan
- Back-to-back ALU ops: add x5 then sub x6,x5,x7. On the cycle sub enters EX: forward_a=EX_MEM_FWD, forward_b=NO_FWD, no stall.
- Distance-2 dependency: add x5; nop; or x8,x5,x5. When `or` is in EX: forward_a and forward_b are both MEM_WB_FWD.
- Double producer: add x5; add x5; sub x9,x5,x0. When sub is in EX: forward_a=EX_MEM_FWD (newest producer wins), forward_b=NO_FWD.
- Load-use: lw x3 then add x4,x3,x1.
  - stall=1 for one cycle, the bubble carries NO_FWD, then add executes with forward_a=MEM_WB_FWD.
  - stall_cycles=1.
- x0 writer: add x0 then add x1,x0,x0. Forwards stay NO_FWD and no stall occurs even when the writer is a load.
- Branch plus reset:
  - branch_taken coincident with a load-use hazard: flush_if_id=1, flush_id_ex=1, stall=0, flush_events=1, stall_cycles unchanged.
  - Then reset_n low mid-stream: all outputs go to reset values asynchronously.
